instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Fetch stage that sits directly upstream of the combinational instruction decoder. It owns the program counter and issues word reads to instruction memory over a variable-latency req/valid handshake.
- It holds each fetched instruction stable on `instr` until the datapath acknowledges retirement.
- On that acknowledgement it resolves the next PC from the decoder's BRANCH/JUMP/JAL signals, the ALU condition result and the register target.
- It also supplies the link address (PC+4) to the register-write path.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.
- TIMEOUT_CYCLES, 255, maximum cycles to wait for imem_valid before flagging imem_timeout; range 1..65535.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  read request; held high until imem_valid
- imem_addr  out  32  word address of request (bits 30:31 always 0)
- imem_valid  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word, sampled when imem_valid=1
- instr  out  32  current instruction; feeds decoder `instruction`
- instr_valid  out  1  instr is valid and awaiting execution
- instr_ack  in  1  datapath retires instr this cycle; resolution inputs sampled now
- pc  out  32  address of instr
- link_addr  out  32  pc+4 (mod 2^32), written to r31 on JAL/JALR
- branch  in  1  decoder BRANCH
- jump  in  1  decoder JUMP
- jump_reg  in  1  1 = JR/JALR (target from register), 0 = J/JAL
- cond_true  in  1  ALU result nonzero (BEQZ/BNEZ condition met)
- reg_target  in  32  rs1 value for JR/JALR
- misalign_err  out  1  one-cycle pulse: computed target had bits 30:31 nonzero
- imem_timeout  out  1  sticky; set when wait counter reaches TIMEOUT_CYCLES, cleared only by reset

Behaviour:
- Reset values:
  - state = S_START; pc = RESET_PC.
  - instr = 32'h0 (NOP); instr_valid, imem_req, misalign_err and imem_timeout = 0.
  - Wait counter = 0.
- States:
  - S_START: one idle cycle after reset deasserts, then go to S_FETCH.
  - S_FETCH: imem_req=1, imem_addr=pc. On imem_valid, latch imem_rdata into instr, set instr_valid=1 on the next edge, go to S_HOLD.
  - S_HOLD: imem_req=0; instr, pc and link_addr stay stable. On instr_ack, load next_pc into pc, clear instr_valid, go to S_FETCH.
- Timing:
  - imem_valid may arrive in the same cycle as the first imem_req. Minimum fetch-to-instr_valid latency is 1 cycle; minimum cycles per instruction is 2.
  - imem_valid outside S_FETCH is ignored.
  - instr_ack outside S_HOLD is ignored.
- Next-PC priority (imm16 = instr[16:31], imm26 = instr[6:31], both sign-extended; all sums mod 2^32):
  1. jump & jump_reg: reg_target
  2. jump & !jump_reg: pc+4+sext(imm26)
  3. branch & cond_true: pc+4+sext(imm16)
  4. otherwise: pc+4
- Jump and branch both asserted: jump wins (decoder never produces this; still defined).
- Misalignment: if the selected target has bits 30:31 ≠ 0, force those bits to 0, load the aligned value, and pulse misalign_err for the one cycle following the ack edge.
- Wrap-around: pc=32'hFFFF_FFFC with no branch gives next pc=32'h0000_0000; link_addr likewise wraps.
- Timeout: the wait counter increments each S_FETCH cycle without imem_valid and clears on leaving S_FETCH. At TIMEOUT_CYCLES, imem_timeout sets; fetch keeps waiting (no abort).
- Reset mid-operation: reset has priority in every state and returns all outputs to reset values on the next edge. Instruction memory shares this reset and drops any in-flight response.

Decomposition:
- Shared package holds:
  - fetch state enum (S_START, S_FETCH, S_HOLD);
  - NOP_INSTR constant (32'h0);
  - field-slice constants for imm16/imm26 positions, shared with the decoder.
- One natural sub-module: next_pc_calc (combinational next-PC mux and adders, plus misalign detect). The FSM, registers and timeout counter stay in the top.

Test Plan:
- Reset, then imem_valid with 0 wait, rdata=32'h2001_0005 → imem_addr=0, instr_valid at cycle 2, instr=32'h2001_0005, pc=0, link_addr=4; ack → next imem_addr=4.
- pc=32'h100, BEQZ with imm16=16'hFFF8, branch=1, cond_true=1, ack → next imem_addr=32'h0FC. Same case with cond_true=0 → 32'h104.
- pc=32'h200, J with imm26=26'h0000010, jump=1, jump_reg=0 → 32'h214. JR with reg_target=32'h0000_3002 → imem_addr=32'h3000, misalign_err pulses for 1 cycle.
- pc=32'hFFFF_FFFC, no branch, ack → imem_addr=0, link_addr was 0. Jump and branch both high → jump target taken.
- TIMEOUT_CYCLES=4, hold imem_valid low 4 cycles → imem_timeout=1, stays 1 after a later valid. Reset asserted during S_HOLD → instr_valid=0, pc=RESET_PC, imem_timeout=0 on the next edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and instruction field layout.
// Immediate slice positions are also used by the decoder.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        S_START,
        S_FETCH,
        S_HOLD
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int IMM16_MSB = 15;
    localparam int IMM26_MSB = 25;

    function automatic logic [31:0] imm16(input logic [31:0] ir);
        return {{(31 - IMM16_MSB){ir[IMM16_MSB]}}, ir[IMM16_MSB:0]};
    endfunction

    function automatic logic [31:0] imm26(input logic [31:0] ir);
        return {{(31 - IMM26_MSB){ir[IMM26_MSB]}}, ir[IMM26_MSB:0]};
    endfunction

endpackage

// File: rtl/instruction_fetch_next_pc_calc.sv
// Next-PC selection: register jump, relative jump, taken branch or
// fall-through, with the target forced to word alignment.
module instruction_fetch_next_pc_calc
    import instruction_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        cond_true,
    input  logic [31:0] reg_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] target;

    assign pc_plus4 = pc + 32'd4;

    // Jump outranks branch even though the decoder never raises both.
    always_comb begin
        if (jump && jump_reg) begin
            target = reg_target;
        end else if (jump) begin
            target = pc_plus4 + imm26(instr);
        end else if (branch && cond_true) begin
            target = pc_plus4 + imm16(instr);
        end else begin
            target = pc_plus4;
        end
    end

    assign misalign = |target[1:0];
    assign next_pc  = {target[31:2], 2'b00};

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads instruction memory, holds the
// instruction until retirement and then steps to the resolved next PC.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic        branch,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        cond_true,
    input  logic [31:0] reg_target,
    output logic        misalign_err,
    output logic        imem_timeout
);

    localparam logic [15:0] TIMEOUT_MAX = 16'(TIMEOUT_CYCLES);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [15:0]  wait_cnt;
    logic         fetch_done;
    logic         retire;
    logic [31:0]  next_pc;
    logic         misalign;

    instruction_fetch_next_pc_calc u_next_pc (
        .pc        (pc),
        .instr     (instr),
        .branch    (branch),
        .jump      (jump),
        .jump_reg  (jump_reg),
        .cond_true (cond_true),
        .reg_target(reg_target),
        .pc_plus4  (link_addr),
        .next_pc   (next_pc),
        .misalign  (misalign)
    );

    assign imem_addr = pc;

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_done  = 1'b0;
        retire      = 1'b0;
        unique case (state)
            S_START: state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    fetch_done = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ack) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_START;
            pc           <= RESET_PC;
            instr        <= NOP_INSTR;
            misalign_err <= 1'b0;
            imem_timeout <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            state        <= state_next;
            misalign_err <= retire && misalign;
            if (fetch_done) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc <= next_pc;
            end
            // Counter saturates; the flag stays set until reset.
            if (state == S_FETCH && !imem_valid) begin
                if (wait_cnt != TIMEOUT_MAX) begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                if (wait_cnt == TIMEOUT_MAX - 16'd1) begin
                    imem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed bench for the fetch stage against a
// transaction-level reference model.
module tb_instruction_fetch;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack = 1'b0;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        branch = 1'b0;
    logic        jump = 1'b0;
    logic        jump_reg = 1'b0;
    logic        cond_true = 1'b0;
    logic [31:0] reg_target = '0;
    logic        misalign_err;
    logic        imem_timeout;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic        m_to;

    instruction_fetch #(
        .RESET_PC      (32'h0000_0000),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .pc          (pc),
        .link_addr   (link_addr),
        .branch      (branch),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .cond_true   (cond_true),
        .reg_target  (reg_target),
        .misalign_err(misalign_err),
        .imem_timeout(imem_timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference next-PC from the architectural rules, in plain arithmetic.
    function automatic void model_next(
        input logic [31:0] cur, input logic [31:0] ir,
        input logic br, input logic jp, input logic jr, input logic ct,
        input logic [31:0] rt,
        output logic [31:0] npc, output logic mis);
        int s16;
        int s26;
        logic [31:0] t;
        s16 = int'($signed(ir[15:0]));
        s26 = int'($signed(ir[25:0]));
        if (jp) t = jr ? rt : cur + 32'd4 + 32'(s26);
        else if (br && ct) t = cur + 32'd4 + 32'(s16);
        else t = cur + 32'd4;
        mis = (t % 4) != 0;
        npc = t - (t % 4);
    endfunction

    // Noise on retirement inputs while not holding; must be ignored.
    task automatic rand_side();
        instr_ack  = 1'($urandom);
        branch     = 1'($urandom);
        jump       = 1'($urandom);
        jump_reg   = 1'($urandom);
        cond_true  = 1'($urandom);
        reg_target = $urandom;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("req", imem_req, 1);
    endtask

    task automatic do_instr(input int w, input logic [31:0] ir,
                            input logic br, input logic jp,
                            input logic jr, input logic ct,
                            input logic [31:0] rt, input int hold);
        logic [31:0] npc;
        logic        mis;
        wait_req();
        check("addr", imem_addr, m_pc);
        repeat (w) begin
            imem_valid = 1'b0;
            rand_side();
            @(negedge clk);
        end
        imem_valid = 1'b1;
        imem_rdata = ir;
        rand_side();
        @(negedge clk);
        imem_valid = 1'b0;
        instr_ack  = 1'b0;
        if (w >= TO) m_to = 1'b1;
        check("instr_valid", instr_valid, 1);
        check("instr", instr, ir);
        check("pc", pc, m_pc);
        check("link", link_addr, m_pc + 32'd4);
        check("timeout", imem_timeout, m_to);
        check("mis_idle", misalign_err, 0);
        repeat (hold) begin
            imem_valid = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clk);
        end
        imem_valid = 1'b0;
        check("instr_hold", instr, ir);
        check("valid_hold", instr_valid, 1);
        model_next(m_pc, ir, br, jp, jr, ct, rt, npc, mis);
        instr_ack  = 1'b1;
        branch     = br;
        jump       = jp;
        jump_reg   = jr;
        cond_true  = ct;
        reg_target = rt;
        @(negedge clk);
        instr_ack = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        check("misalign", misalign_err, mis);
        check("valid_clr", instr_valid, 0);
        m_pc = npc;
    endtask

    task automatic jr_to(input logic [31:0] t);
        do_instr(0, $urandom, 0, 1, 1, 0, t, 0);
    endtask

    initial begin
        m_pc = 32'h0;
        m_to = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_mis", misalign_err, 0);
        check("rst_to", imem_timeout, 0);
        reset = 1'b0;
        @(negedge clk);
        check("start_req", imem_req, 1);

        do_instr(0, 32'h2001_0005, 0, 0, 0, 0, 0, 0);
        check("seq_pc", m_pc, 32'h4);
        jr_to(32'h100);
        do_instr(0, 32'h1000_FFF8, 1, 0, 0, 1, 0, 1);
        jr_to(32'h100);
        do_instr(0, 32'h1000_FFF8, 1, 0, 0, 0, 0, 0);
        jr_to(32'h200);
        do_instr(2, 32'h0800_0010, 0, 1, 0, 0, 0, 0);
        do_instr(0, $urandom, 0, 1, 1, 0, 32'h0000_3002, 0);
        jr_to(32'hFFFF_FFFC);
        do_instr(1, $urandom, 0, 0, 0, 0, 0, 2);
        do_instr(0, 32'h0802_0010, 1, 1, 0, 1, 0, 0);
        do_instr(TO, $urandom, 0, 0, 0, 0, 0, 0);
        do_instr(0, $urandom, 0, 0, 0, 0, 0, 0);

        wait_req();
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_valid = 1'b0;
        check("pre_rst_valid", instr_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_pc", pc, 32'h0);
        check("mid_rst_to", imem_timeout, 0);
        check("mid_rst_instr", instr, 32'h0);
        reset = 1'b0;
        m_pc  = 32'h0;
        m_to  = 1'b0;

        for (int i = 0; i < 80; i++) begin
            int k;
            logic [31:0] rt;
            k  = $urandom_range(0, 4);
            rt = $urandom;
            if (k == 0) rt[1:0] = 2'b00;
            do_instr($urandom_range(0, TO - 1), $urandom,
                     k == 3 || k == 4, k == 0 || k == 1 || k == 4,
                     k == 0 || k == 1, 1'($urandom), rt,
                     $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
